// File: rtl/cmp_hold_pkg.sv
// Shared types for the hysteretic comparator: decision states, sample classes
// and the width of the agreement counter.
package cmp_hold_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GT   = 2'd1,
    LT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    C_GT = 2'd0,
    C_LT = 2'd1,
    C_EQ = 2'd2
  } class_t;

  // Decision state a non-EQ class would move the FSM into.
  function automatic state_t class_to_state(input class_t c);
    return (c == C_LT) ? LT : GT;
  endfunction

  function automatic logic class_matches(input class_t c, input state_t s);
    return ((c == C_GT) && (s == GT)) || ((c == C_LT) && (s == LT));
  endfunction

endpackage

// File: rtl/cmp_classify.sv
// Unsigned magnitude classifier: reports whether a is greater, less or equal to b.
module cmp_classify
  import cmp_hold_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output class_t           cls
);

  always_comb begin
    cls = C_EQ;
    if (a > b)      cls = C_GT;
    else if (a < b) cls = C_LT;
  end

endmodule

// File: rtl/cmp_hold_fsm.sv
// Debounced compare decision: a new GT/LT decision is taken only after
// STABLE_CNT consecutive agreeing valid samples; EQ samples break the run.
module cmp_hold_fsm
  import cmp_hold_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STABLE_CNT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             y,
  output logic             z,
  output logic             changed,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CNT);

  class_t            cls;
  state_t            state_q, state_d;
  class_t            cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic              y_q, y_d, z_q, z_d, changed_q, changed_d;

  cmp_classify #(.WIDTH(WIDTH)) u_classify (
    .a   (a),
    .b   (b),
    .cls (cls)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    cnt_nxt   = '0;

    if (in_valid) begin
      if (cls == C_EQ || class_matches(cls, state_q)) begin
        cnt_d = '0;
      end else begin
        // A class that disagrees with the candidate restarts the run at 1.
        if (cls == cand_q) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end else begin
          cand_d  = cls;
          cnt_nxt = CNT_W'(1);
        end
        if (cnt_nxt == STABLE_C) begin
          state_d   = class_to_state(cls);
          cnt_d     = '0;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
    end

    // y remembers a past GT decision through an LT decision.
    unique case (state_d)
      GT:      begin y_d = 1'b1; z_d = 1'b0; end
      LT:      begin y_d = y_q;  z_d = 1'b1; end
      default: begin y_d = 1'b0; z_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cand_q    <= C_GT;
      cnt_q     <= '0;
      y_q       <= 1'b0;
      z_q       <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      z_q       <= z_d;
      changed_q <= changed_d;
    end
  end

  assign y       = y_q;
  assign z       = z_q;
  assign changed = changed_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cmp_hold_fsm.sv
// Directed bench: default-parameter instance (WIDTH=8, STABLE_CNT=3) plus a
// WIDTH=16, STABLE_CNT=1 instance for the single-sample decision case.
module tb_cmp_hold_fsm;

  logic        clk = 1'b0;
  logic        rst0_n, vld0;
  logic [7:0]  a0, b0;
  logic        y0, z0, chg0;
  logic [1:0]  st0;

  logic        rst1_n, vld1;
  logic [15:0] a1, b1;
  logic        y1, z1, chg1;
  logic [1:0]  st1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_hold_fsm #(.WIDTH(8), .STABLE_CNT(3)) dut0 (
    .clk(clk), .reset_n(rst0_n), .in_valid(vld0), .a(a0), .b(b0),
    .y(y0), .z(z0), .changed(chg0), .state_o(st0)
  );

  cmp_hold_fsm #(.WIDTH(16), .STABLE_CNT(1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .in_valid(vld1), .a(a1), .b(b1),
    .y(y1), .z(z1), .changed(chg1), .state_o(st1)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs packed as {y, z, changed, state_o} for compact checks.
  function automatic logic [15:0] o0();
    return {11'd0, y0, z0, chg0, st0};
  endfunction
  function automatic logic [15:0] o1();
    return {11'd0, y1, z1, chg1, st1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s0(input logic v, input logic [7:0] a, input logic [7:0] b);
    vld0 = v; a0 = a; b0 = b;
    tick();
  endtask

  task automatic rst0();
    rst0_n = 1'b0; vld0 = 1'b0;
    tick();
    rst0_n = 1'b1;
  endtask

  initial begin
    rst0_n = 1'b0; vld0 = 1'b0; a0 = '0; b0 = '0;
    rst1_n = 1'b0; vld1 = 1'b0; a1 = '0; b1 = '0;
    tick(); tick();
    chk("reset0", o0(), 16'h0);
    chk("reset1", o1(), 16'h0);

    // GT decision after three samples; first sample on release edge counts.
    rst0_n = 1'b1;
    s0(1, 8'd5, 8'd2); chk("gt_s1", o0(), 16'h0);
    s0(1, 8'd5, 8'd2); chk("gt_s2", o0(), 16'h0);
    s0(1, 8'd5, 8'd2); chk("gt_s3", o0(), {11'd0, 5'b10101});
    s0(0, 8'd0, 8'd9); chk("gt_pulse_end", o0(), {11'd0, 5'b10001});

    // GT -> LT; y sticks.
    s0(1, 8'd1, 8'd9);
    s0(1, 8'd1, 8'd9); chk("lt_s2", o0(), {11'd0, 5'b10001});
    s0(1, 8'd1, 8'd9); chk("lt_s3", o0(), {11'd0, 5'b11110});
    s0(0, 8'd1, 8'd9); chk("lt_hold", o0(), {11'd0, 5'b11010});

    // EQ breaks the GT run from LT.
    s0(1, 8'd7, 8'd3);
    s0(1, 8'd7, 8'd3);
    s0(1, 8'd4, 8'd4);
    s0(1, 8'd7, 8'd3);
    s0(1, 8'd7, 8'd3); chk("eq_break", o0(), {11'd0, 5'b11010});
    s0(1, 8'd7, 8'd3); chk("eq_then_gt", o0(), {11'd0, 5'b10101});

    // Invalid gaps keep the count.
    rst0();
    s0(1, 8'd200, 8'd100);
    repeat (4) s0(0, 8'd0, 8'd0);
    s0(1, 8'd200, 8'd100);
    repeat (4) s0(0, 8'd0, 8'd0);
    chk("gap_hold", o0(), 16'h0);
    s0(1, 8'd200, 8'd100); chk("gap_trans", o0(), {11'd0, 5'b10101});

    // Reset mid-count discards the run.
    rst0();
    s0(1, 8'd9, 8'd8);
    s0(1, 8'd9, 8'd8);
    rst0_n = 1'b0; vld0 = 1'b0;
    tick(); chk("mid_rst", o0(), 16'h0);
    rst0_n = 1'b1;
    s0(1, 8'd9, 8'd8); chk("mid_rst_after", o0(), 16'h0);

    // Reset during the changed pulse suppresses it.
    s0(1, 8'd9, 8'd8);
    s0(1, 8'd9, 8'd8); chk("pulse_pre", o0(), {11'd0, 5'b10101});
    rst0_n = 1'b0; vld0 = 1'b0;
    tick(); chk("pulse_rst", o0(), 16'h0);
    rst0_n = 1'b1;

    // LT from IDLE leaves y clear.
    repeat (3) s0(1, 8'd0, 8'd255);
    chk("idle_lt", o0(), {11'd0, 5'b01110});

    // Alternating classes never settle.
    rst0();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) s0(1, 8'd3, 8'd1);
      else            s0(1, 8'd1, 8'd3);
    end
    chk("alternate", o0(), 16'h0);
    vld0 = 1'b0;

    // STABLE_CNT=1: every differing sample decides immediately.
    rst1_n = 1'b1;
    vld1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0000;
    tick(); chk("sc1_gt", o1(), {11'd0, 5'b10101});
    a1 = 16'h0000; b1 = 16'hFFFF;
    tick(); chk("sc1_lt", o1(), {11'd0, 5'b11110});
    a1 = 16'h1234; b1 = 16'h1234;
    tick(); chk("sc1_eq", o1(), {11'd0, 5'b11010});
    vld1 = 1'b0;
    tick(); chk("sc1_idle_in", o1(), {11'd0, 5'b11010});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
